// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32I pipeline and its unified-memory arbiter.
package rv32_pkg;

    localparam int ARB_MAX_DSTREAK = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/rv32_arb_pick.sv
// Owner choice for the memory arbiter: data first, but a fetch is forced through
// once MAX_DSTREAK data grants have gone by while it waited.
module rv32_arb_pick
    import rv32_pkg::*;
#(
    parameter int MAX_DSTREAK = ARB_MAX_DSTREAK
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       idle_i,
    input  logic       if_req_i,
    input  logic       dm_req_i,
    output logic       pick_valid_o,
    output arb_owner_t pick_owner_o
);

    localparam int               CNT_W      = $clog2(MAX_DSTREAK + 1);
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_DSTREAK);

    logic [CNT_W-1:0] dstreak_q;
    logic [CNT_W-1:0] dstreak_d;
    logic             fetchDue;

    assign fetchDue     = if_req_i && (dstreak_q == STREAK_MAX);
    assign pick_valid_o = idle_i && (if_req_i || dm_req_i);
    assign pick_owner_o = (dm_req_i && !fetchDue) ? OWN_DM : OWN_IF;

    // The streak only moves in IDLE, where every cycle with if_req high makes a selection.
    always_comb begin
        dstreak_d = dstreak_q;
        if (idle_i) begin
            if (!if_req_i || pick_owner_o == OWN_IF) begin
                dstreak_d = '0;
            end else if (dstreak_q != STREAK_MAX) begin
                dstreak_d = dstreak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dstreak_q <= '0;
        end else begin
            dstreak_q <= dstreak_d;
        end
    end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and the MEM stage,
// one outstanding transaction at a time, routing each response to its owner.
module rv32_mem_arbiter
    import rv32_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = ARB_MAX_DSTREAK
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t        state_q;
    arb_state_t        state_d;
    arb_owner_t        owner_q;
    logic              mem_we_q;
    logic [BE_W-1:0]   mem_be_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic       isIdle;
    logic       pickValid;
    arb_owner_t pickOwner;
    logic       accept;
    logic       respond;

    assign isIdle = (state_q == ARB_IDLE);

    rv32_arb_pick #(
        .MAX_DSTREAK (MAX_DSTREAK)
    ) u_pick (
        .clk          (clk),
        .rst          (rst),
        .idle_i       (isIdle),
        .if_req_i     (if_req),
        .dm_req_i     (dm_req),
        .pick_valid_o (pickValid),
        .pick_owner_o (pickOwner)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE:  if (pickValid)  state_d = ARB_ISSUE;
            ARB_ISSUE: if (mem_ready)  state_d = ARB_WAIT;
            ARB_WAIT:  if (mem_rvalid) state_d = ARB_IDLE;
            default:                   state_d = ARB_IDLE;
        endcase
    end

    // Request fields are captured only in the selecting IDLE cycle and then held.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_IF;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (pickValid) begin
                owner_q <= pickOwner;
                if (pickOwner == OWN_DM) begin
                    mem_we_q    <= dm_we;
                    mem_be_q    <= dm_be;
                    mem_addr_q  <= dm_addr;
                    mem_wdata_q <= dm_wdata;
                end else begin
                    mem_we_q    <= 1'b0;
                    mem_be_q    <= '1;
                    mem_addr_q  <= if_addr;
                    mem_wdata_q <= '0;
                end
            end
        end
    end

    assign mem_req   = (state_q == ARB_ISSUE);
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = !isIdle;

    // A response outside WAIT is stray and never reaches either port.
    assign accept    = mem_req && mem_ready;
    assign respond   = (state_q == ARB_WAIT) && mem_rvalid;

    assign if_gnt    = accept && (owner_q == OWN_IF);
    assign dm_gnt    = accept && (owner_q == OWN_DM);
    assign if_rvalid = respond && (owner_q == OWN_IF);
    assign dm_rvalid = respond && (owner_q == OWN_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Scoreboard bench for rv32_mem_arbiter: directed corner cases followed by
// randomized fetch/data traffic against a behavioural arbitration model.
module tb_rv32_mem_arbiter;

    localparam int MAXD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_ready, mem_rvalid;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    always #5 clk = ~clk;

    rv32_mem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MAX_DSTREAK (MAXD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_be      (dm_be),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_gnt     (dm_gnt),
        .dm_rvalid  (dm_rvalid),
        .dm_rdata   (dm_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    typedef struct {
        bit          isData;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t        expQ[$];
    logic [7:0]  gntLog[$];
    logic [31:0] memWords[int];
    int          checks   = 0;
    int          failures = 0;

    int autoReq      = 0;
    int ifRate       = 0;
    int dmRate       = 0;
    int memReadyRate = 100;
    int memMinLat    = 1;
    int memMaxLat    = 1;
    bit memStray     = 1'b0;

    bit          ifGntSeen, dmGntSeen, accSeen, accWe;
    logic [3:0]  accBe;
    logic [31:0] accAddr, accWdata;

    function automatic logic [31:0] memRead(input logic [31:0] addr);
        int idx;
        idx = int'(addr >> 2);
        if (memWords.exists(idx)) return memWords[idx];
        return {addr[15:0], ~addr[15:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    // Requesters hold req until gnt, then either re-request immediately or go quiet.
    task automatic applyStimulus();
        if (autoReq == 0) return;
        if (ifGntSeen) if_req = 1'b0;
        if (dmGntSeen) dm_req = 1'b0;
        if (!if_req && int'($urandom_range(99)) < ifRate) begin
            if_req  = 1'b1;
            if_addr = 32'($urandom_range(63)) << 2;
        end
        if (!dm_req && int'($urandom_range(99)) < dmRate) begin
            dm_req   = 1'b1;
            dm_we    = 1'($urandom_range(1));
            dm_be    = 4'($urandom_range(15, 1));
            dm_addr  = 32'($urandom_range(63)) << 2;
            dm_wdata = $urandom();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        applyStimulus();
    endtask

    always @(negedge clk) begin : sampleHandshakes
        ifGntSeen = if_gnt;
        dmGntSeen = dm_gnt;
        accSeen   = mem_req && mem_ready;
        accWe     = mem_we;
        accBe     = mem_be;
        accAddr   = mem_addr;
        accWdata  = mem_wdata;
    end

    // Memory: accepts at mem_ready, answers after a random latency, loads see earlier stores.
    initial begin : memResponder
        int          delay;
        bit          pending;
        logic [31:0] data;
        logic [31:0] word;
        pending    = 1'b0;
        delay      = 0;
        data       = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (accSeen) begin
                pending = 1'b1;
                delay   = int'($urandom_range(memMaxLat, memMinLat));
                if (accWe) begin
                    word = memRead(accAddr);
                    for (int b = 0; b < 4; b++)
                        if (accBe[b]) word[8*b +: 8] = accWdata[8*b +: 8];
                    memWords[int'(accAddr >> 2)] = word;
                    data = '0;
                end else begin
                    data = memRead(accAddr);
                end
            end
            if (pending) begin
                delay--;
                if (delay <= 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = data;
                    pending    = 1'b0;
                end
            end
            if (memStray) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hBAD0_BAD0;
                memStray   = 1'b0;
            end
            mem_ready = (int'($urandom_range(99)) < memReadyRate);
        end
    end

    // Reference model: decides who should own the next transaction from the request
    // lines alone, counting data wins that happened while a fetch was waiting.
    localparam int P_IDLE  = 0;
    localparam int P_ISSUE = 1;
    localparam int P_WAIT  = 2;
    int modelPhase  = P_IDLE;
    int modelStreak = 0;

    always @(negedge clk) begin : refModel
        txn_t t;
        if (rst) begin
            modelPhase  = P_IDLE;
            modelStreak = 0;
        end else begin
            case (modelPhase)
                P_IDLE: begin
                    if (if_req || dm_req) begin
                        t.isData = dm_req && !(if_req && modelStreak >= MAXD);
                        if (t.isData) begin
                            t.we    = dm_we;
                            t.be    = dm_be;
                            t.addr  = dm_addr;
                            t.wdata = dm_wdata;
                            t.rdata = dm_we ? 32'h0 : memRead(dm_addr);
                        end else begin
                            t.we    = 1'b0;
                            t.be    = 4'hF;
                            t.addr  = if_addr;
                            t.wdata = '0;
                            t.rdata = memRead(if_addr);
                        end
                        expQ.push_back(t);
                        modelStreak = (if_req && t.isData) ? ((modelStreak < MAXD) ? modelStreak + 1 : MAXD) : 0;
                        modelPhase  = P_ISSUE;
                    end else begin
                        modelStreak = 0;
                    end
                end
                P_ISSUE: if (mem_ready)  modelPhase = P_WAIT;
                default: if (mem_rvalid) modelPhase = P_IDLE;
            endcase
        end
    end

    int stallCycles = 0;

    always @(negedge clk) begin : monitor
        if (mem_req) begin
            checkOutput("memreq_has_txn", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
                checkOutput("mem_we", 32'(mem_we), 32'(expQ[0].we));
                checkOutput("mem_be", 32'(mem_be), 32'(expQ[0].be));
                checkOutput("mem_addr", mem_addr, expQ[0].addr);
                if (expQ[0].we) checkOutput("mem_wdata", mem_wdata, expQ[0].wdata);
            end
        end
        if (if_gnt || dm_gnt) begin
            gntLog.push_back(dm_gnt ? 8'h44 : 8'h49);
            checkOutput("single_gnt", 32'(if_gnt && dm_gnt), 32'd0);
            checkOutput("gnt_has_txn", 32'(expQ.size() != 0), 32'd1);
            checkOutput("gnt_with_ready", 32'(mem_ready), 32'd1);
            if (expQ.size() != 0) checkOutput("gnt_owner", 32'(dm_gnt), 32'(expQ[0].isData));
        end
        if (if_rvalid || dm_rvalid) begin
            checkOutput("single_rvalid", 32'(if_rvalid && dm_rvalid), 32'd0);
            checkOutput("rvalid_has_txn", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
                checkOutput("rvalid_owner", 32'(dm_rvalid), 32'(expQ[0].isData));
                checkOutput("rdata", dm_rvalid ? dm_rdata : if_rdata, expQ[0].rdata);
                checkOutput("other_rdata", dm_rvalid ? if_rdata : dm_rdata, 32'd0);
                expQ.delete(0);
            end
        end
        if (expQ.size() != 0) stallCycles++;
        else stallCycles = 0;
        if (stallCycles > 200) begin
            checkOutput("response_timeout", 32'(stallCycles), 32'd0);
            stallCycles = 0;
        end
        if (rst) expQ.delete();
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin : mainSeq
        string pat;
        int    bpGnts;
        rst      = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_be    = '0;
        dm_addr  = '0;
        dm_wdata = '0;
        memWords[int'(32'h100 >> 2)] = 32'h0050_0093;

        tick();
        tick();
        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset_mem_addr", mem_addr, 32'd0);
        checkOutput("reset_mem_be", 32'(mem_be), 32'd0);
        checkOutput("reset_gnts", 32'({if_gnt, dm_gnt, if_rvalid, dm_rvalid}), 32'd0);
        checkOutput("reset_rdata", if_rdata | dm_rdata, 32'd0);
        tick(); rst = 1'b0;
        tick();

        $display("[TB] lone fetch");
        tick(); if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk); checkOutput("lone_c0_mem_req", 32'(mem_req), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("lone_c1_mem_req", 32'(mem_req), 32'd1);
        checkOutput("lone_c1_if_gnt", 32'(if_gnt), 32'd1);
        checkOutput("lone_c1_mem_be", 32'(mem_be), 32'hF);
        tick(); if_req = 1'b0;
        @(negedge clk);
        checkOutput("lone_c2_if_rvalid", 32'(if_rvalid), 32'd1);
        checkOutput("lone_c2_if_rdata", if_rdata, 32'h0050_0093);
        tick();
        @(negedge clk); checkOutput("lone_c3_busy", 32'(busy), 32'd0);

        $display("[TB] store");
        tick(); dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'hF; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
        tick();
        @(negedge clk);
        checkOutput("store_mem_we", 32'(mem_we), 32'd1);
        checkOutput("store_mem_addr", mem_addr, 32'h200);
        checkOutput("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        checkOutput("store_dm_gnt", 32'(dm_gnt), 32'd1);
        checkOutput("store_if_gnt", 32'(if_gnt), 32'd0);
        tick(); dm_req = 1'b0;
        @(negedge clk);
        checkOutput("store_dm_rvalid", 32'(dm_rvalid), 32'd1);
        checkOutput("store_if_quiet", 32'(if_rvalid) | if_rdata, 32'd0);
        tick();
        tick();

        $display("[TB] contention");
        gntLog.delete();
        autoReq = 1; ifRate = 100; dmRate = 100;
        for (int i = 0; i < 200 && gntLog.size() < 10; i++) tick();
        checkOutput("contention_grant_count", 32'(gntLog.size() >= 10), 32'd1);
        pat = "DDDDIDDDDI";
        for (int i = 0; i < 10 && i < gntLog.size(); i++)
            checkOutput($sformatf("contention_grant_%0d", i), 32'(gntLog[i]), 32'(pat[i]));
        ifRate = 0; dmRate = 0;
        repeat (30) tick();

        $display("[TB] random traffic");
        memReadyRate = 60; memMaxLat = 3;
        for (int blk = 0; blk < 8; blk++) begin
            ifRate = int'($urandom_range(90, 5));
            dmRate = int'($urandom_range(90, 5));
            repeat (200) tick();
        end
        ifRate = 0; dmRate = 0;
        repeat (80) tick();
        @(negedge clk);
        checkOutput("drain_queue_empty", 32'(expQ.size()), 32'd0);
        checkOutput("drain_busy", 32'(busy), 32'd0);
        autoReq = 0; memReadyRate = 100; memMaxLat = 1;
        tick();

        $display("[TB] backpressure");
        memReadyRate = 0;
        tick(); dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'h3; dm_addr = 32'h40; dm_wdata = '0;
        bpGnts = 0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            @(negedge clk);
            checkOutput("bp_mem_req", 32'(mem_req), 32'd1);
            checkOutput("bp_mem_addr", mem_addr, 32'h40);
            checkOutput("bp_mem_be", 32'(mem_be), 32'h3);
            bpGnts += int'(dm_gnt) + int'(if_gnt);
        end
        tick(); memReadyRate = 100;
        @(negedge clk);
        checkOutput("bp_gnt_on_ready", 32'(dm_gnt), 32'd1);
        bpGnts += int'(dm_gnt) + int'(if_gnt);
        tick(); dm_req = 1'b0;
        @(negedge clk); bpGnts += int'(dm_gnt) + int'(if_gnt);
        tick();
        @(negedge clk); bpGnts += int'(dm_gnt) + int'(if_gnt);
        checkOutput("bp_gnt_pulses", 32'(bpGnts), 32'd1);

        $display("[TB] reset in wait");
        memMinLat = 4; memMaxLat = 4;
        tick(); if_req = 1'b1; if_addr = 32'h80;
        tick();
        @(negedge clk); checkOutput("rw_if_gnt", 32'(if_gnt), 32'd1);
        tick(); if_req = 1'b0;
        tick(); rst = 1'b1;
        @(negedge clk); checkOutput("rw_busy_in_wait", 32'(busy), 32'd1);
        tick(); rst = 1'b0;
        @(negedge clk);
        checkOutput("rw_post_busy", 32'(busy), 32'd0);
        checkOutput("rw_post_mem_addr", mem_addr, 32'd0);
        checkOutput("rw_post_mem_be", 32'(mem_be), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("rw_stray_routed", 32'({if_rvalid, dm_rvalid}), 32'd0);
        checkOutput("rw_stray_rdata", if_rdata | dm_rdata, 32'd0);
        checkOutput("rw_stray_busy", 32'(busy), 32'd0);
        tick();
        memMinLat = 1; memMaxLat = 1;

        $display("[TB] stray rvalid in idle");
        tick(); memStray = 1'b1;
        @(negedge clk);
        checkOutput("stray_routed", 32'({if_rvalid, dm_rvalid}), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("stray_busy", 32'(busy), 32'd0);
        checkOutput("stray_mem_req", 32'(mem_req), 32'd0);

        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
